// File: rtl/ctrl_pipe_hazard_unit_pkg.sv
// ctrl_pipe_hazard_unit_pkg: control encodings, pipeline bundles and forwarding selects shared by the hazard unit
package ctrl_pipe_hazard_unit_pkg;
  localparam int BUNDLE_REG_W = 5;
  localparam int BUNDLE_ALUOP_W = 4;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic memRead;
    logic memWrite;
    logic branch;
    logic jump;
    logic aluSrcA;
    logic aluSrcB;
    logic jal;
    logic [BUNDLE_ALUOP_W-1:0] aluOp;
    logic [BUNDLE_REG_W-1:0] dest;
    logic [BUNDLE_REG_W-1:0] rs;
    logic [BUNDLE_REG_W-1:0] rt;
  } ctrlBundle;
  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic memRead;
    logic memWrite;
    logic jal;
    logic [BUNDLE_REG_W-1:0] dest;
  } memBundle;
  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic jal;
    logic [BUNDLE_REG_W-1:0] dest;
  } wbBundle;
  localparam ctrlBundle BUBBLE = '0;
endpackage

// File: rtl/ctrl_pipe_hazard_unit_fwd_select.sv
// ctrl_pipe_hazard_unit_fwd_select: EX/MEM-over-MEM/WB forwarding priority for one EX source operand
module ctrl_pipe_hazard_unit_fwd_select import ctrl_pipe_hazard_unit_pkg::*; (
  input  logic [BUNDLE_REG_W-1:0] exSrc,
  input  logic                    memRegWrite,
  input  logic                    memMemToReg,
  input  logic [BUNDLE_REG_W-1:0] memDest,
  input  logic                    wbRegWrite,
  input  logic [BUNDLE_REG_W-1:0] wbDest,
  output logic [1:0]              fwd
);
  logic memHit;
  logic wbHit;
  always_comb begin
    memHit = memRegWrite & ~memMemToReg & (memDest != '0) & (memDest == exSrc);
    wbHit = wbRegWrite & (wbDest != '0) & (wbDest == exSrc);
    fwd = memHit ? FWD_MEM : wbHit ? FWD_WB : FWD_REG;
  end
endmodule

// File: rtl/ctrl_pipe_hazard_unit.sv
// ctrl_pipe_hazard_unit: control pipeline registers with load-use stall, EX redirect flush and forwarding selects
module ctrl_pipe_hazard_unit import ctrl_pipe_hazard_unit_pkg::*; #(
  parameter int REG_AW = BUNDLE_REG_W,
  parameter int ALUOP_W = BUNDLE_ALUOP_W,
  parameter int LINK_REG = 31
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ID_VALID,
  input  logic               ID_REGDST,
  input  logic               ID_JUMP,
  input  logic               ID_BRANCH,
  input  logic               ID_MEMREAD,
  input  logic               ID_MEMTOREG,
  input  logic               ID_REGWRITE,
  input  logic               ID_MEMWRITE,
  input  logic [ALUOP_W-1:0] ID_ALUOP,
  input  logic               ID_ALUSRCA,
  input  logic               ID_ALUSRCB,
  input  logic               ID_JAL,
  input  logic [REG_AW-1:0]  ID_RS,
  input  logic [REG_AW-1:0]  ID_RT,
  input  logic [REG_AW-1:0]  ID_RD,
  input  logic               BR_TAKEN_EX,
  output logic [ALUOP_W-1:0] EX_ALUOP,
  output logic               EX_ALUSRCA,
  output logic               EX_ALUSRCB,
  output logic               EX_BRANCH,
  output logic               EX_JUMP,
  output logic [REG_AW-1:0]  EX_RS,
  output logic [REG_AW-1:0]  EX_RT,
  output logic [1:0]         FWD_A,
  output logic [1:0]         FWD_B,
  output logic               MEM_MEMREAD,
  output logic               MEM_MEMWRITE,
  output logic               WB_REGWRITE,
  output logic               WB_MEMTOREG,
  output logic               WB_JAL,
  output logic [REG_AW-1:0]  WB_DEST,
  output logic               PC_WE,
  output logic               IFID_WE,
  output logic               IFID_FLUSH
);
  ctrlBundle idBundle;
  ctrlBundle ex;
  memBundle mem;
  wbBundle wb;
  logic [BUNDLE_REG_W-1:0] idDest;
  logic stall;
  logic redirect;
  always_comb begin
    idDest = ID_JAL ? BUNDLE_REG_W'(LINK_REG) : ID_REGDST ? ID_RD : ID_RT;
    idBundle = ID_VALID ? '{
      regWrite: ID_REGWRITE & (idDest != '0),
      memToReg: ID_MEMTOREG,
      memRead: ID_MEMREAD,
      memWrite: ID_MEMWRITE,
      branch: ID_BRANCH,
      jump: ID_JUMP,
      aluSrcA: ID_ALUSRCA,
      aluSrcB: ID_ALUSRCB,
      jal: ID_JAL,
      aluOp: ID_ALUOP,
      dest: idDest,
      rs: ID_RS,
      rt: ID_RT
    } : BUBBLE;
    stall = ex.memRead & (ex.dest != '0) & ((ex.dest == ID_RS) | (ex.dest == ID_RT)) & ID_VALID;
    redirect = ex.jump | (ex.branch & BR_TAKEN_EX);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex <= BUBBLE;
      mem <= '0;
      wb <= '0;
    end else begin
      ex <= (stall | redirect) ? BUBBLE : idBundle;
      mem <= '{regWrite: ex.regWrite, memToReg: ex.memToReg, memRead: ex.memRead,
               memWrite: ex.memWrite, jal: ex.jal, dest: ex.dest};
      wb <= '{regWrite: mem.regWrite, memToReg: mem.memToReg, jal: mem.jal, dest: mem.dest};
    end
  end
  ctrl_pipe_hazard_unit_fwd_select fwdA (
    .exSrc(ex.rs), .memRegWrite(mem.regWrite), .memMemToReg(mem.memToReg), .memDest(mem.dest),
    .wbRegWrite(wb.regWrite), .wbDest(wb.dest), .fwd(FWD_A)
  );
  ctrl_pipe_hazard_unit_fwd_select fwdB (
    .exSrc(ex.rt), .memRegWrite(mem.regWrite), .memMemToReg(mem.memToReg), .memDest(mem.dest),
    .wbRegWrite(wb.regWrite), .wbDest(wb.dest), .fwd(FWD_B)
  );
  // redirect overrides a coincident stall so the wrong-path fetch is discarded, not held
  assign PC_WE = RST_N & (redirect | ~stall);
  assign IFID_WE = RST_N & (redirect | ~stall);
  assign IFID_FLUSH = ~RST_N | redirect;
  assign EX_ALUOP = ex.aluOp;
  assign EX_ALUSRCA = ex.aluSrcA;
  assign EX_ALUSRCB = ex.aluSrcB;
  assign EX_BRANCH = ex.branch;
  assign EX_JUMP = ex.jump;
  assign EX_RS = ex.rs;
  assign EX_RT = ex.rt;
  assign MEM_MEMREAD = mem.memRead;
  assign MEM_MEMWRITE = mem.memWrite;
  assign WB_REGWRITE = wb.regWrite;
  assign WB_MEMTOREG = wb.memToReg;
  assign WB_JAL = wb.jal;
  assign WB_DEST = wb.dest;
endmodule

// File: tb/tb_ctrl_pipe_hazard_unit.sv
// tb_ctrl_pipe_hazard_unit: directed stall, flush, forwarding and reset vectors for ctrl_pipe_hazard_unit
module tb_ctrl_pipe_hazard_unit;
  import ctrl_pipe_hazard_unit_pkg::*;
  logic CLK = 1'b0;
  logic RST_N;
  logic ID_VALID, ID_REGDST, ID_JUMP, ID_BRANCH, ID_MEMREAD, ID_MEMTOREG, ID_REGWRITE, ID_MEMWRITE;
  logic [3:0] ID_ALUOP;
  logic ID_ALUSRCA, ID_ALUSRCB, ID_JAL;
  logic [4:0] ID_RS, ID_RT, ID_RD;
  logic BR_TAKEN_EX;
  logic [3:0] EX_ALUOP;
  logic EX_ALUSRCA, EX_ALUSRCB, EX_BRANCH, EX_JUMP;
  logic [4:0] EX_RS, EX_RT;
  logic [1:0] FWD_A, FWD_B;
  logic MEM_MEMREAD, MEM_MEMWRITE, WB_REGWRITE, WB_MEMTOREG, WB_JAL;
  logic [4:0] WB_DEST;
  logic PC_WE, IFID_WE, IFID_FLUSH;
  int vectors = 0;
  int miscompares = 0;

  ctrl_pipe_hazard_unit dut (
    .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_REGDST(ID_REGDST), .ID_JUMP(ID_JUMP),
    .ID_BRANCH(ID_BRANCH), .ID_MEMREAD(ID_MEMREAD), .ID_MEMTOREG(ID_MEMTOREG),
    .ID_REGWRITE(ID_REGWRITE), .ID_MEMWRITE(ID_MEMWRITE), .ID_ALUOP(ID_ALUOP),
    .ID_ALUSRCA(ID_ALUSRCA), .ID_ALUSRCB(ID_ALUSRCB), .ID_JAL(ID_JAL), .ID_RS(ID_RS),
    .ID_RT(ID_RT), .ID_RD(ID_RD), .BR_TAKEN_EX(BR_TAKEN_EX), .EX_ALUOP(EX_ALUOP),
    .EX_ALUSRCA(EX_ALUSRCA), .EX_ALUSRCB(EX_ALUSRCB), .EX_BRANCH(EX_BRANCH), .EX_JUMP(EX_JUMP),
    .EX_RS(EX_RS), .EX_RT(EX_RT), .FWD_A(FWD_A), .FWD_B(FWD_B), .MEM_MEMREAD(MEM_MEMREAD),
    .MEM_MEMWRITE(MEM_MEMWRITE), .WB_REGWRITE(WB_REGWRITE), .WB_MEMTOREG(WB_MEMTOREG),
    .WB_JAL(WB_JAL), .WB_DEST(WB_DEST), .PC_WE(PC_WE), .IFID_WE(IFID_WE), .IFID_FLUSH(IFID_FLUSH)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setId(input logic v, rdst, jmp, br, mrd, m2r, rw, mwr, input logic [3:0] op,
                       input logic sa, sb, jl, input logic [4:0] rs, rt, rd);
    ID_VALID = v; ID_REGDST = rdst; ID_JUMP = jmp; ID_BRANCH = br; ID_MEMREAD = mrd;
    ID_MEMTOREG = m2r; ID_REGWRITE = rw; ID_MEMWRITE = mwr; ID_ALUOP = op;
    ID_ALUSRCA = sa; ID_ALUSRCB = sb; ID_JAL = jl; ID_RS = rs; ID_RT = rt; ID_RD = rd;
    #1;
  endtask

  task automatic bubble();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic rType(input logic [3:0] op, input logic [4:0] rs, rt, rd);
    setId(1, 1, 0, 0, 0, 0, 1, 0, op, 0, 0, 0, rs, rt, rd);
  endtask
  task automatic lw(input logic [4:0] rs, rt);
    setId(1, 0, 0, 0, 1, 1, 1, 0, ALU_ADD, 0, 1, 0, rs, rt, 5'd0);
  endtask
  task automatic sw(input logic [4:0] rs, rt);
    setId(1, 0, 0, 0, 0, 0, 0, 1, ALU_ADD, 0, 1, 0, rs, rt, 5'd0);
  endtask
  task automatic beq(input logic [4:0] rs, rt);
    setId(1, 0, 0, 1, 0, 0, 0, 0, ALU_SUB, 0, 0, 0, rs, rt, 5'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    BR_TAKEN_EX = 1'b0;
    bubble();
    chk("rst_pc_we", 32'(PC_WE), 0);
    chk("rst_ifid_we", 32'(IFID_WE), 0);
    chk("rst_ifid_flush", 32'(IFID_FLUSH), 1);
    chk("rst_fwd_a", 32'(FWD_A), 0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    chk("rel_pc_we", 32'(PC_WE), 1);
    chk("rel_ifid_flush", 32'(IFID_FLUSH), 0);
    // load-use: lw $8 then add rs=8
    lw(5'd1, 5'd8);
    tick();
    rType(ALU_ADD, 5'd8, 5'd2, 5'd10);
    chk("lu_ex_aluop", 32'(EX_ALUOP), 32'(ALU_ADD));
    chk("lu_pc_we", 32'(PC_WE), 0);
    chk("lu_ifid_we", 32'(IFID_WE), 0);
    chk("lu_flush", 32'(IFID_FLUSH), 0);
    tick();
    chk("lu_bubble_rs", 32'(EX_RS), 0);
    chk("lu_bubble_aluop", 32'(EX_ALUOP), 0);
    chk("lu_after_pc_we", 32'(PC_WE), 1);
    tick();
    chk("lu_ex_rs", 32'(EX_RS), 8);
    chk("lu_wb_dest", 32'(WB_DEST), 8);
    chk("lu_wb_m2r", 32'(WB_MEMTOREG), 1);
    chk("lu_fwd_a", 32'(FWD_A), 32'(FWD_WB));
    chk("lu_fwd_b", 32'(FWD_B), 32'(FWD_REG));
    // back-to-back: add $9, sub rs=9 rt=9
    rType(ALU_ADD, 5'd3, 5'd4, 5'd9);
    tick();
    rType(ALU_SUB, 5'd9, 5'd9, 5'd11);
    tick();
    chk("b2b_fwd_a", 32'(FWD_A), 32'(FWD_MEM));
    chk("b2b_fwd_b", 32'(FWD_B), 32'(FWD_MEM));
    // one unrelated instruction in between
    rType(ALU_ADD, 5'd1, 5'd2, 5'd12);
    tick();
    rType(ALU_OR, 5'd1, 5'd2, 5'd14);
    tick();
    rType(ALU_ADD, 5'd12, 5'd7, 5'd15);
    tick();
    chk("gap_fwd_a", 32'(FWD_A), 32'(FWD_WB));
    chk("gap_fwd_b", 32'(FWD_B), 32'(FWD_REG));
    // $0: load into $0 must not stall, consumer of $0 must not forward
    lw(5'd1, 5'd0);
    tick();
    rType(ALU_ADD, 5'd0, 5'd0, 5'd16);
    chk("r0_pc_we", 32'(PC_WE), 1);
    chk("r0_ifid_we", 32'(IFID_WE), 1);
    tick();
    chk("r0_ex_aluop", 32'(EX_ALUOP), 32'(ALU_ADD));
    chk("r0_fwd_a", 32'(FWD_A), 32'(FWD_REG));
    chk("r0_fwd_b", 32'(FWD_B), 32'(FWD_REG));
    // taken beq, with a store behind it
    beq(5'd1, 5'd2);
    tick();
    BR_TAKEN_EX = 1'b1;
    sw(5'd1, 5'd2);
    chk("beq_ex_branch", 32'(EX_BRANCH), 1);
    chk("beq_flush", 32'(IFID_FLUSH), 1);
    chk("beq_pc_we", 32'(PC_WE), 1);
    tick();
    BR_TAKEN_EX = 1'b0;
    bubble();
    chk("beq_bubble_aluop", 32'(EX_ALUOP), 0);
    chk("beq_bubble_branch", 32'(EX_BRANCH), 0);
    tick();
    chk("beq_bubble_memwrite", 32'(MEM_MEMWRITE), 0);
    // not-taken beq lets the store through
    beq(5'd1, 5'd2);
    tick();
    sw(5'd1, 5'd2);
    chk("nt_flush", 32'(IFID_FLUSH), 0);
    tick();
    bubble();
    chk("nt_ex_aluop", 32'(EX_ALUOP), 32'(ALU_ADD));
    chk("nt_ex_srcb", 32'(EX_ALUSRCB), 1);
    tick();
    chk("nt_memwrite", 32'(MEM_MEMWRITE), 1);
    // jal writes $31
    setId(1, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    tick();
    bubble();
    chk("jal_ex_jump", 32'(EX_JUMP), 1);
    chk("jal_flush", 32'(IFID_FLUSH), 1);
    tick();
    tick();
    chk("jal_wb_dest", 32'(WB_DEST), 31);
    chk("jal_wb_jal", 32'(WB_JAL), 1);
    chk("jal_wb_regwrite", 32'(WB_REGWRITE), 1);
    // EX holds a load to $8 that also jumps; ID reads $8
    setId(1, 0, 1, 0, 1, 1, 1, 0, ALU_ADD, 0, 1, 0, 5'd3, 5'd8, 5'd0);
    tick();
    rType(ALU_ADD, 5'd8, 5'd2, 5'd17);
    chk("sr_flush", 32'(IFID_FLUSH), 1);
    chk("sr_pc_we", 32'(PC_WE), 1);
    chk("sr_ifid_we", 32'(IFID_WE), 1);
    tick();
    chk("sr_bubble_rs", 32'(EX_RS), 0);
    chk("sr_bubble_jump", 32'(EX_JUMP), 0);
    // fill all stages, then reset asynchronously
    rType(ALU_ADD, 5'd1, 5'd2, 5'd20);
    tick();
    lw(5'd3, 5'd21);
    tick();
    rType(ALU_ADD, 5'd20, 5'd5, 5'd22);
    tick();
    chk("pre_wb_dest", 32'(WB_DEST), 20);
    chk("pre_mem_memread", 32'(MEM_MEMREAD), 1);
    chk("pre_fwd_a", 32'(FWD_A), 32'(FWD_WB));
    #2;
    RST_N = 1'b0;
    #1;
    chk("mr_ex_aluop", 32'(EX_ALUOP), 0);
    chk("mr_ex_rs", 32'(EX_RS), 0);
    chk("mr_mem_memread", 32'(MEM_MEMREAD), 0);
    chk("mr_wb_regwrite", 32'(WB_REGWRITE), 0);
    chk("mr_wb_dest", 32'(WB_DEST), 0);
    chk("mr_fwd_a", 32'(FWD_A), 0);
    chk("mr_pc_we", 32'(PC_WE), 0);
    chk("mr_ifid_flush", 32'(IFID_FLUSH), 1);
    #2;
    RST_N = 1'b1;
    bubble();
    tick();
    chk("mr_rel_pc_we", 32'(PC_WE), 1);
    chk("mr_rel_ifid_we", 32'(IFID_WE), 1);
    chk("mr_rel_flush", 32'(IFID_FLUSH), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
